// File: rtl/fmrv32im_timer_mc.sv
// Multi-channel machine timer: shared prescaled up-counter feeding NUM_CH compare
// channels with sticky pending flags, per-channel IRQ enable and optional
// periodic auto-clear driven by channel 0.
module fmrv32im_timer_mc #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32,
  parameter int PRE_W  = 8
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              BUS_WE,
  input  logic [3:0]        BUS_ADDR,
  input  logic [31:0]       BUS_WDATA,
  output logic [31:0]       BUS_RDATA,
  output logic [NUM_CH-1:0] IRQ,
  output logic              EXPIRED
);

  localparam logic [3:0] ADDR_COUNT  = 4'h0;
  localparam logic [3:0] ADDR_PRE    = 4'h1;
  localparam logic [3:0] ADDR_CTRL   = 4'h2;
  localparam logic [3:0] ADDR_PEND   = 4'h3;
  localparam logic [3:0] ADDR_IRQ_EN = 4'h4;
  localparam int         ADDR_CMP0   = 5;

  logic [CNT_W-1:0]  count_reg;
  logic [CNT_W-1:0]  count_next;
  logic [PRE_W-1:0]  pre_reg;
  logic [PRE_W-1:0]  presc_reg;
  logic [PRE_W-1:0]  presc_next;
  logic [1:0]        ctrl_reg;
  logic [NUM_CH-1:0] pend_reg;
  logic [NUM_CH-1:0] pend_next;
  logic [NUM_CH-1:0] irq_en_reg;
  logic [CNT_W-1:0]  cmp_reg [NUM_CH];
  logic [NUM_CH-1:0] match;

  logic wr_count;
  logic wr_pre;
  logic wr_ctrl;
  logic wr_pend;
  logic wr_irq_en;
  logic tick;
  logic ctrl_en;
  logic ctrl_auto_clr;

  assign wr_count  = BUS_WE && (BUS_ADDR == ADDR_COUNT);
  assign wr_pre    = BUS_WE && (BUS_ADDR == ADDR_PRE);
  assign wr_ctrl   = BUS_WE && (BUS_ADDR == ADDR_CTRL);
  assign wr_pend   = BUS_WE && (BUS_ADDR == ADDR_PEND);
  assign wr_irq_en = BUS_WE && (BUS_ADDR == ADDR_IRQ_EN);

  assign ctrl_en       = ctrl_reg[0];
  assign ctrl_auto_clr = ctrl_reg[1];

  // A COUNT write takes the whole cycle: no tick, no increment, no match.
  assign tick = ctrl_en && (presc_reg == pre_reg) && !wr_count;

  // Per-channel compare registers and match against the pre-increment count.
  // The match sees the old compare value even when it is rewritten this cycle.
  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign match[gi] = (count_reg == cmp_reg[gi]);

      // Compare register: reset to all-ones so nothing matches by accident.
      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
          cmp_reg[gi] <= '1;
        end else if (BUS_WE && (BUS_ADDR == 4'(ADDR_CMP0 + gi))) begin
          cmp_reg[gi] <= BUS_WDATA[CNT_W-1:0];
        end
      end
    end
  endgenerate

  // Next-state for prescaler, counter and pending flags.
  always_comb begin
    presc_next = presc_reg;
    if (wr_count || wr_pre) begin
      presc_next = '0;
    end else if (ctrl_en) begin
      presc_next = (presc_reg == pre_reg) ? '0 : presc_reg + PRE_W'(1);
    end

    count_next = count_reg;
    if (wr_count) begin
      count_next = BUS_WDATA[CNT_W-1:0];
    end else if (tick) begin
      if (ctrl_auto_clr && match[0]) begin
        count_next = '0;
      end else begin
        count_next = count_reg + CNT_W'(1);
      end
    end

    // Set beats a same-cycle W1C of the same bit.
    pend_next = pend_reg;
    if (wr_pend) begin
      pend_next = pend_next & ~BUS_WDATA[NUM_CH-1:0];
    end
    if (tick) begin
      pend_next = pend_next | match;
    end
  end

  // Timer state registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      count_reg  <= '0;
      pre_reg    <= '0;
      presc_reg  <= '0;
      ctrl_reg   <= '0;
      pend_reg   <= '0;
      irq_en_reg <= '0;
    end else begin
      count_reg <= count_next;
      presc_reg <= presc_next;
      pend_reg  <= pend_next;
      if (wr_pre) begin
        pre_reg <= BUS_WDATA[PRE_W-1:0];
      end
      if (wr_ctrl) begin
        ctrl_reg <= BUS_WDATA[1:0];
      end
      if (wr_irq_en) begin
        irq_en_reg <= BUS_WDATA[NUM_CH-1:0];
      end
    end
  end

  assign IRQ     = pend_reg & irq_en_reg;
  assign EXPIRED = |IRQ;

  // Zero-latency register read; unmapped slots read zero.
  always_comb begin
    BUS_RDATA = '0;
    case (BUS_ADDR)
      ADDR_COUNT:  BUS_RDATA[CNT_W-1:0]  = count_reg;
      ADDR_PRE:    BUS_RDATA[PRE_W-1:0]  = pre_reg;
      ADDR_CTRL:   BUS_RDATA[1:0]        = ctrl_reg;
      ADDR_PEND:   BUS_RDATA[NUM_CH-1:0] = pend_reg;
      ADDR_IRQ_EN: BUS_RDATA[NUM_CH-1:0] = irq_en_reg;
      default: begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (BUS_ADDR == 4'(ADDR_CMP0 + i)) begin
            BUS_RDATA[CNT_W-1:0] = cmp_reg[i];
          end
        end
      end
    endcase
  end

endmodule

// File: tb/tb_fmrv32im_timer_mc.sv
// Directed bench for fmrv32im_timer_mc: a default 32-bit/4-channel instance and
// an 8-bit/2-channel instance share the bus; each task checks one feature.
module tb_fmrv32im_timer_mc;

  logic        CLK;
  logic        RST_N;
  logic        BUS_WE;
  logic [3:0]  BUS_ADDR;
  logic [31:0] BUS_WDATA;
  logic [31:0] BUS_RDATA;
  logic [3:0]  IRQ;
  logic        EXPIRED;
  logic [31:0] rdata8;
  logic [1:0]  irq8;
  logic        expired8;

  int checks   = 0;
  int failures = 0;

  fmrv32im_timer_mc #(.NUM_CH(4), .CNT_W(32), .PRE_W(8)) dut (
    .CLK(CLK), .RST_N(RST_N), .BUS_WE(BUS_WE), .BUS_ADDR(BUS_ADDR),
    .BUS_WDATA(BUS_WDATA), .BUS_RDATA(BUS_RDATA), .IRQ(IRQ), .EXPIRED(EXPIRED)
  );

  fmrv32im_timer_mc #(.NUM_CH(2), .CNT_W(8), .PRE_W(8)) dut8 (
    .CLK(CLK), .RST_N(RST_N), .BUS_WE(BUS_WE), .BUS_ADDR(BUS_ADDR),
    .BUS_WDATA(BUS_WDATA), .BUS_RDATA(rdata8), .IRQ(irq8), .EXPIRED(expired8)
  );

  initial CLK = 1'b0;
  always #10 CLK = ~CLK;

  // One-cycle bus write; returns 1 time unit after the capturing edge.
  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    BUS_WE = 1'b1; BUS_ADDR = a; BUS_WDATA = d;
    @(posedge CLK); #1;
    BUS_WE = 1'b0;
    $display("WR addr=%0h data=%h", a, d);
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] d);
    BUS_ADDR = a; #1; d = BUS_RDATA;
  endtask

  task automatic rd8(input logic [3:0] a, output logic [31:0] d);
    BUS_ADDR = a; #1; d = rdata8;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic test_reset;
    logic [31:0] d;
    wr(4'h1, 0);
    for (int ch = 0; ch < 4; ch++) wr(4'(5 + ch), 32'd2);
    wr(4'h4, 32'hF);
    wr(4'h0, 0);
    wr(4'h2, 32'h1);
    step(3);
    rd(4'h3, d);
    if (d !== 32'hF) begin failures++; $display("FAIL reset_pre_pend got=%h exp=%h", d, 32'hF); end
    checks++;
    if (IRQ !== 4'hF) begin failures++; $display("FAIL reset_pre_irq got=%h exp=%h", IRQ, 4'hF); end
    checks++;
    #2 RST_N = 1'b0;
    #1;
    if (IRQ !== 4'h0) begin failures++; $display("FAIL reset_irq got=%h exp=0", IRQ); end
    checks++;
    if (EXPIRED !== 1'b0) begin failures++; $display("FAIL reset_expired got=%b exp=0", EXPIRED); end
    checks++;
    for (int a = 0; a < 5; a++) begin
      rd(4'(a), d);
      if (d !== 32'h0) begin failures++; $display("FAIL reset_reg%0d got=%h exp=0", a, d); end
      checks++;
    end
    for (int ch = 0; ch < 4; ch++) begin
      rd(4'(5 + ch), d);
      if (d !== 32'hFFFFFFFF) begin failures++; $display("FAIL reset_cmp%0d got=%h exp=ffffffff", ch, d); end
      checks++;
    end
    rd8(4'h5, d);
    if (d !== 32'hFF) begin failures++; $display("FAIL reset_cmp8 got=%h exp=ff", d); end
    checks++;
    step(1);
    RST_N = 1'b1;
    step(1);
  endtask

  task automatic test_prescale;
    logic [31:0] d;
    wr(4'h1, 32'd3);
    wr(4'h0, 0);
    wr(4'h2, 32'h1);
    step(4);
    rd(4'h0, d);
    if (d !== 32'd1) begin failures++; $display("FAIL pre_4cyc got=%h exp=1", d); end
    checks++;
    step(16);
    rd(4'h0, d);
    if (d !== 32'd5) begin failures++; $display("FAIL pre_20cyc got=%h exp=5", d); end
    checks++;
    wr(4'h2, 0);
    step(10);
    rd(4'h0, d);
    if (d !== 32'd5) begin failures++; $display("FAIL pre_hold got=%h exp=5", d); end
    checks++;
  endtask

  task automatic test_match;
    logic [31:0] d;
    wr(4'h1, 0);
    wr(4'h7, 32'd10);
    wr(4'h4, 32'h4);
    wr(4'h3, 32'hF);
    wr(4'h0, 0);
    wr(4'h2, 32'h1);
    step(10);
    if (EXPIRED !== 1'b0) begin failures++; $display("FAIL match_early got=%b exp=0", EXPIRED); end
    checks++;
    step(1);
    rd(4'h3, d);
    if (d !== 32'h4) begin failures++; $display("FAIL match_pend got=%h exp=4", d); end
    checks++;
    if (EXPIRED !== 1'b1 || IRQ !== 4'h4) begin
      failures++; $display("FAIL match_irq got=%b/%h exp=1/4", EXPIRED, IRQ);
    end
    checks++;
    wr(4'h2, 0);
    wr(4'h3, 32'h4);
    rd(4'h3, d);
    if (d !== 32'h0 || EXPIRED !== 1'b0) begin
      failures++; $display("FAIL match_w1c got=%h/%b exp=0/0", d, EXPIRED);
    end
    checks++;
    wr(4'h4, 0);
    wr(4'h0, 32'd9);
    wr(4'h2, 32'h1);
    step(2);
    rd(4'h3, d);
    if (d !== 32'h4) begin failures++; $display("FAIL match_masked_pend got=%h exp=4", d); end
    checks++;
    if (IRQ !== 4'h0 || EXPIRED !== 1'b0) begin
      failures++; $display("FAIL match_masked_irq got=%h/%b exp=0/0", IRQ, EXPIRED);
    end
    checks++;
    wr(4'h2, 0);
  endtask

  task automatic test_periodic;
    logic [31:0] d;
    wr(4'h5, 32'd4);
    wr(4'h6, 32'd2);
    wr(4'h3, 32'hF);
    wr(4'h0, 0);
    wr(4'h2, 32'h3);
    for (int i = 1; i <= 5; i++) begin
      step(1);
      rd(4'h0, d);
      if (d !== 32'(i % 5)) begin failures++; $display("FAIL periodic_count%0d got=%h exp=%h", i, d, i % 5); end
      checks++;
    end
    rd(4'h3, d);
    if (d !== 32'h3) begin failures++; $display("FAIL periodic_pend1 got=%h exp=3", d); end
    checks++;
    wr(4'h3, 32'h3);
    rd(4'h3, d);
    if (d !== 32'h0) begin failures++; $display("FAIL periodic_clr got=%h exp=0", d); end
    checks++;
    step(2);
    rd(4'h3, d);
    if (d !== 32'h2) begin failures++; $display("FAIL periodic_ch1 got=%h exp=2", d); end
    checks++;
    step(2);
    rd(4'h3, d);
    if (d !== 32'h3) begin failures++; $display("FAIL periodic_pend2 got=%h exp=3", d); end
    checks++;
    rd(4'h0, d);
    if (d !== 32'h0) begin failures++; $display("FAIL periodic_wrap got=%h exp=0", d); end
    checks++;
    wr(4'h2, 0);
  endtask

  task automatic test_wrap;
    logic [31:0] d;
    wr(4'h1, 0);
    wr(4'h5, 32'h10);
    wr(4'h6, 32'h20);
    wr(4'h3, 32'hF);
    wr(4'h0, 32'hFF);
    wr(4'h2, 32'h1);
    step(1);
    rd8(4'h0, d);
    if (d !== 32'h0) begin failures++; $display("FAIL wrap_count got=%h exp=0", d); end
    checks++;
    rd8(4'h3, d);
    if (d !== 32'h0) begin failures++; $display("FAIL wrap_nopend got=%h exp=0", d); end
    checks++;
    wr(4'h2, 0);
    wr(4'h6, 32'hFF);
    wr(4'h0, 32'hFF);
    wr(4'h2, 32'h1);
    step(1);
    rd8(4'h3, d);
    if (d !== 32'h2) begin failures++; $display("FAIL wrap_pend_ff got=%h exp=2", d); end
    checks++;
    wr(4'h2, 0);
    wr(4'h0, 32'h1234);
    rd8(4'h0, d);
    if (d !== 32'h34) begin failures++; $display("FAIL wrap_trunc got=%h exp=34", d); end
    checks++;
    wr(4'h7, 32'h55);
    rd8(4'h7, d);
    if (d !== 32'h0) begin failures++; $display("FAIL wrap_unmapped got=%h exp=0", d); end
    checks++;
  endtask

  task automatic test_collisions;
    logic [31:0] d;
    wr(4'h6, 32'd3);
    wr(4'h3, 32'hF);
    wr(4'h0, 0);
    wr(4'h2, 32'h1);
    step(3);
    wr(4'h3, 32'h2);
    rd(4'h3, d);
    if (d !== 32'h2) begin failures++; $display("FAIL coll_w1c_set got=%h exp=2", d); end
    checks++;
    wr(4'h2, 0);
    wr(4'h3, 32'h2);
    rd(4'h3, d);
    if (d !== 32'h0) begin failures++; $display("FAIL coll_w1c_plain got=%h exp=0", d); end
    checks++;
    wr(4'h5, 32'd7);
    wr(4'h0, 32'd5);
    wr(4'h2, 32'h1);
    step(2);
    wr(4'h0, 32'h100);
    rd(4'h0, d);
    if (d !== 32'h100) begin failures++; $display("FAIL coll_count_load got=%h exp=100", d); end
    checks++;
    rd(4'h3, d);
    if (d !== 32'h0) begin failures++; $display("FAIL coll_no_match got=%h exp=0", d); end
    checks++;
    step(1);
    rd(4'h0, d);
    if (d !== 32'h101) begin failures++; $display("FAIL coll_resume got=%h exp=101", d); end
    checks++;
    wr(4'h2, 0);
  endtask

  initial begin
    RST_N = 1'b0; BUS_WE = 1'b0; BUS_ADDR = '0; BUS_WDATA = '0;
    repeat (2) @(posedge CLK);
    #1 RST_N = 1'b1;
    step(1);
    test_reset();
    test_prescale();
    test_match();
    test_periodic();
    test_wrap();
    test_collisions();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
